// File: rtl/oled_if.sv
// Pin bundle for the Pmod OLED (SSD1306, 4-wire write-only SPI plus power/reset).
// The controller drives through the master modport; the panel side observes via slave.
interface oled_if;
    logic oled_spi_clk;
    logic oled_spi_data;
    logic oled_vdd;
    logic oled_vbat;
    logic oled_reset_n;
    logic oled_dc_n;

    modport master (
        output oled_spi_clk, oled_spi_data, oled_vdd, oled_vbat, oled_reset_n, oled_dc_n
    );

    modport slave (
        input oled_spi_clk, oled_spi_data, oled_vdd, oled_vbat, oled_reset_n, oled_dc_n
    );
endinterface

// File: rtl/oled_top.sv
// SSD1306 128x32 power-up sequencer, init command player and checkerboard frame streamer.
// Optional macro OLED_REFRESH_EN: resend the 512-byte frame continuously instead of stopping.
module oled_top #(
    parameter int CLK_DIV = 10,
    parameter int T_1MS   = 100000,
    parameter int T_100MS = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    oled_if.master     oled,
    output logic [3:0] dbg_state
);

    localparam int DW   = $clog2(T_100MS + 1);
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        PWR_VDD, WAIT_VDD, CMD_OFF, RST_LO, RST_HI, CMD_PUMP,
        PWR_VBAT, WAIT_VBAT, CMD_CFG, DATA, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [3:0]      cmd_idx_q, cmd_idx_d;
    logic [8:0]      data_cnt_q, data_cnt_d;
    logic            vdd_q, vdd_d, vbat_q, vbat_d, rstn_q, rstn_d, dc_q, dc_d;
    logic            sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            start;
    logic [7:0]      tx_byte;

    function automatic logic [7:0] cmd_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_rom = 8'hAE;
            4'd1:    cmd_rom = 8'h8D;
            4'd2:    cmd_rom = 8'h14;
            4'd3:    cmd_rom = 8'hD9;
            4'd4:    cmd_rom = 8'hF1;
            4'd5:    cmd_rom = 8'hA1;
            4'd6:    cmd_rom = 8'hC8;
            4'd7:    cmd_rom = 8'hDA;
            4'd8:    cmd_rom = 8'h20;
            4'd9:    cmd_rom = 8'h20;
            4'd10:   cmd_rom = 8'h00;
            4'd11:   cmd_rom = 8'hAF;
            default: cmd_rom = 8'h00;
        endcase
    endfunction

    // Sequencer. Command states play the ROM up to an end index, one byte per
    // idle engine; the state is left only after the last byte has fully shifted out.
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        cmd_idx_d  = cmd_idx_q;
        data_cnt_d = data_cnt_q;
        vdd_d      = vdd_q;
        vbat_d     = vbat_q;
        rstn_d     = rstn_q;
        dc_d       = dc_q;
        start      = 1'b0;
        tx_byte    = 8'h00;
        case (state_q)
            PWR_VDD: begin
                vdd_d   = 1'b0;
                dly_d   = '0;
                state_d = WAIT_VDD;
            end
            WAIT_VDD: begin
                if (dly_q == DW'(T_1MS - 1)) begin
                    dly_d   = '0;
                    state_d = CMD_OFF;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            CMD_OFF, CMD_PUMP, CMD_CFG: begin
                if (!busy_q) begin
                    if ((state_q == CMD_OFF  && cmd_idx_q == 4'd1) ||
                        (state_q == CMD_PUMP && cmd_idx_q == 4'd5) ||
                        (state_q == CMD_CFG  && cmd_idx_q == 4'd12)) begin
                        dly_d = '0;
                        case (state_q)
                            CMD_OFF: begin
                                rstn_d  = 1'b0;
                                state_d = RST_LO;
                            end
                            CMD_PUMP: state_d = PWR_VBAT;
                            default: begin
                                dc_d    = 1'b1;
                                state_d = DATA;
                            end
                        endcase
                    end else begin
                        start     = 1'b1;
                        tx_byte   = cmd_rom(cmd_idx_q);
                        cmd_idx_d = cmd_idx_q + 4'd1;
                    end
                end
            end
            RST_LO, RST_HI: begin
                if (dly_q == DW'(T_1MS - 1)) begin
                    dly_d = '0;
                    if (state_q == RST_LO) begin
                        rstn_d  = 1'b1;
                        state_d = RST_HI;
                    end else begin
                        state_d = CMD_PUMP;
                    end
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            PWR_VBAT: begin
                vbat_d  = 1'b0;
                dly_d   = '0;
                state_d = WAIT_VBAT;
            end
            WAIT_VBAT: begin
                if (dly_q == DW'(T_100MS - 1)) begin
                    dly_d   = '0;
                    state_d = CMD_CFG;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            DATA: begin
                if (!busy_q) begin
                    start      = 1'b1;
                    tx_byte    = data_cnt_q[0] ? 8'h55 : 8'hAA;
                    data_cnt_d = data_cnt_q + 9'd1;
                    // Leave on the start of the final byte; the engine finishes it alone.
                    if (data_cnt_q == 9'd511) state_d = DONE;
                end
            end
            DONE: begin
`ifdef OLED_REFRESH_EN
                state_d = DATA;
`else
                state_d = DONE;
`endif
            end
            default: state_d = PWR_VDD;
        endcase
    end

    // SPI engine: mode 3, SCLK falls with each new MOSI bit, byte ends with SCLK high.
    always_comb begin
        shift_d   = shift_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        if (start) begin
            shift_d   = tx_byte;
            mosi_d    = tx_byte[7];
            sclk_d    = 1'b0;
            busy_d    = 1'b1;
            div_d     = '0;
            bit_cnt_d = 3'd0;
        end else if (busy_q) begin
            if (div_q == DIVW'(CLK_DIV - 1)) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else if (bit_cnt_q == 3'd7) begin
                    busy_d = 1'b0;
                end else begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = {shift_q[6:0], 1'b0};
                    mosi_d    = shift_q[6];
                end
            end else begin
                div_d = div_q + DIVW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= PWR_VDD;
            dly_q      <= '0;
            cmd_idx_q  <= '0;
            data_cnt_q <= '0;
            vdd_q      <= 1'b1;
            vbat_q     <= 1'b1;
            rstn_q     <= 1'b1;
            dc_q       <= 1'b0;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            cmd_idx_q  <= cmd_idx_d;
            data_cnt_q <= data_cnt_d;
            vdd_q      <= vdd_d;
            vbat_q     <= vbat_d;
            rstn_q     <= rstn_d;
            dc_q       <= dc_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
        end
    end

    assign oled.oled_spi_clk  = sclk_q;
    assign oled.oled_spi_data = mosi_q;
    assign oled.oled_vdd      = vdd_q;
    assign oled.oled_vbat     = vbat_q;
    assign oled.oled_reset_n  = rstn_q;
    assign oled.oled_dc_n     = dc_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_oled_top.sv
// Bench for oled_top: decodes the SPI pins into {dc_n, byte} and checks them against
// a stream built from the panel's command list and checkerboard rule, plus power/reset timing.
module tb_oled_top;
    localparam int CD   = 2;
    localparam int T1   = 20;
    localparam int T100 = 50;
    localparam int NCMD = 12;
    localparam int BYTE_GAP = 16 * CD + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dbg_state;

    oled_if oif ();

    oled_top #(.CLK_DIV(CD), .T_1MS(T1), .T_100MS(T100)) dut (
        .clock     (clk),
        .reset     (reset),
        .oled      (oif),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         start_q[$];
    logic [7:0] cmd_list [NCMD] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1,
                                    8'hC8, 8'hDA, 8'h20, 8'h20, 8'h00, 8'hAF};

    always @(posedge clk) cyc <= cyc + 1;

    // Panel-side decoder: shift MOSI in on SCLK rising edges, MSB first.
    int         bit_n = 0;
    int         start_cyc = 0;
    int         sclk_edges = 0;
    logic [7:0] sh = 8'h00;
    logic       prev_sclk = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            bit_n     = 0;
            prev_sclk = 1'b1;
        end else begin
            if (prev_sclk === 1'b1 && oif.oled_spi_clk === 1'b0) begin
                sclk_edges++;
                if (bit_n == 0) start_cyc = cyc;
            end
            if (prev_sclk === 1'b0 && oif.oled_spi_clk === 1'b1) begin
                sclk_edges++;
                sh = {sh[6:0], oif.oled_spi_data};
                bit_n++;
                if (bit_n == 8) begin
                    obs_q.push_back({oif.oled_dc_n, sh});
                    start_q.push_back(start_cyc);
                    bit_n = 0;
                end
            end
            prev_sclk = oif.oled_spi_clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vdd"},  32'(oif.oled_vdd), 32'd1);
        chk({tag, "_vbat"}, 32'(oif.oled_vbat), 32'd1);
        chk({tag, "_rstn"}, 32'(oif.oled_reset_n), 32'd1);
        chk({tag, "_dc"},   32'(oif.oled_dc_n), 32'd0);
        chk({tag, "_sclk"}, 32'(oif.oled_spi_clk), 32'd1);
        chk({tag, "_mosi"}, 32'(oif.oled_spi_data), 32'd0);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int c = 0;
        while (obs_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_bytes_arrived"}, 32'(obs_q.size() >= n), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int n);
        int gap_err = 0;
        for (int i = 0; i < n && i < obs_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        for (int i = NCMD + 1; i < n && i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != BYTE_GAP) gap_err++;
        chk({tag, "_data_byte_spacing_errs"}, 32'(gap_err), 32'd0);
    endtask

    task automatic wait_pin_low(input string tag, input int which, input int budget);
        int   c = 0;
        logic v;
        v = (which == 0) ? oif.oled_reset_n : oif.oled_vbat;
        while (v !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
            v = (which == 0) ? oif.oled_reset_n : oif.oled_vbat;
        end
        chk({tag, "_went_low"}, 32'(v), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        int edges0;

        for (int i = 0; i < NCMD; i++) exp_q.push_back({1'b0, cmd_list[i]});
        for (int i = 0; i < 512; i++) exp_q.push_back({1'b1, (i % 2 == 1) ? 8'h55 : 8'hAA});

        // Reset held 3 cycles, then released between edges.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset");
        reset = 1'b0;
        chk("vdd_before_first_edge", 32'(oif.oled_vdd), 32'd1);
        @(negedge clk);
        chk("vdd_on_first_edge", 32'(oif.oled_vdd), 32'd0);

        // Power sequence: panel reset pulse after 0xAE, VBAT only after 0xF1.
        wait_pin_low("rstn", 0, 2000);
        chk("bytes_at_rstn_fall", 32'(obs_q.size()), 32'd1);
        chk("vbat_off_at_rstn_fall", 32'(oif.oled_vbat), 32'd1);
        n = 0;
        while (oif.oled_reset_n === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("rstn_low_cycles", 32'(n), 32'(T1));
        wait_pin_low("vbat", 1, 2000);
        chk("bytes_at_vbat_on", 32'(obs_q.size()), 32'd5);
        if (obs_q.size() >= 5) chk("last_byte_before_vbat", 32'(obs_q[4]), {23'd0, 1'b0, 8'hF1});

        // Full command list and frame.
        wait_bytes("run1", NCMD + 512, 40000);
        check_stream("run1", NCMD + 512);

        // Idle link after the frame.
        edges0 = sclk_edges;
        repeat (1000) @(negedge clk);
        chk("idle_sclk_edges", 32'(sclk_edges), 32'(edges0));
        chk("idle_vdd",  32'(oif.oled_vdd), 32'd0);
        chk("idle_vbat", 32'(oif.oled_vbat), 32'd0);
        chk("idle_rstn", 32'(oif.oled_reset_n), 32'd1);
        chk("idle_sclk", 32'(oif.oled_spi_clk), 32'd1);
        chk("idle_dc",   32'(oif.oled_dc_n), 32'd1);

        // Restart, then interrupt partway through a random point of the frame.
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset_from_done");
        obs_q.delete();
        start_q.delete();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        reset = 1'b0;
        k = $urandom_range(1, 400);
        wait_bytes("run2", NCMD + k, 40000);
        check_stream("run2", NCMD + k);
        repeat ($urandom_range(0, 40)) @(negedge clk);
        chk("pre_midreset_dc", 32'(oif.oled_dc_n), 32'd1);
        chk("pre_midreset_vbat", 32'(oif.oled_vbat), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        obs_q.delete();
        start_q.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("vdd_after_mid_reset", 32'(oif.oled_vdd), 32'd0);

        // Replay must match the first run's commands and frame start.
        wait_bytes("run3", NCMD + 16, 40000);
        check_stream("run3", NCMD + 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
